// File: rtl/seven_seg_scan_if.sv
// Display register bundle between the CPU-side writer and the seven-segment scanner.
// The scanner takes the slave view; the writer (or a testbench) takes the master view.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output data, dp, digit_en, blank_lz, load,
    input  seg, dp_out, an, frame_tick
  );

  modport slave (
    input  data, dp, digit_en, blank_lz, load,
    output seg, dp_out, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, frame-aligned
// double buffering of the displayed value, live leading-zero blanking and digit enables.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scan_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Glyph bits are ordered {g,f,e,d,c,b,a}, i.e. bit 0 is segment a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1100111;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b1111100;
      4'hC:    g = 7'b0111001;
      4'hD:    g = 7'b1011110;
      4'hE:    g = 7'b1111001;
      4'hF:    g = 7'b1110001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DW-1:0]         pdata_r;
  logic [NUM_DIGITS-1:0] pdp_r;
  logic                  pv_r;
  logic [DW-1:0]         sdata_r;
  logic [NUM_DIGITS-1:0] sdp_r;
  logic                  wrap_r;
  logic [6:0]            seg_r;
  logic                  dp_out_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  frame_tick_r;

  logic                  step_s;
  logic                  wrap_s;
  logic [3:0]            nib_s;
  logic                  dp_sel_s;
  logic                  en_sel_s;
  logic                  lz_s;
  logic [NUM_DIGITS-1:0] an_hot_s;
  logic [6:0]            seg_on_s;
  logic                  dp_on_s;
  logic [NUM_DIGITS-1:0] an_on_s;

  assign step_s = (cnt_r == CNT_LAST);
  assign wrap_s = step_s && (idx_r == IDX_LAST);

  // Select the current digit's nibble, dp and enable; blanking scans from the top digit down.
  always_comb begin : digit_select
    logic above_zero;
    above_zero = 1'b1;
    nib_s      = 4'h0;
    dp_sel_s   = 1'b0;
    en_sel_s   = 1'b0;
    lz_s       = 1'b0;
    an_hot_s   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (sdata_r[4*i +: 4] == 4'h0);
      if (idx_r == IDX_W'(i)) begin
        nib_s       = sdata_r[4*i +: 4];
        dp_sel_s    = sdp_r[i];
        en_sel_s    = bus.digit_en[i];
        lz_s        = bus.blank_lz && above_zero && (i != 0);
        an_hot_s[i] = 1'b1;
      end else begin
        an_hot_s[i] = 1'b0;
      end
    end
  end

  // Active-high view of the next output word; a disabled digit is fully dark.
  always_comb begin
    seg_on_s = 7'h00;
    dp_on_s  = 1'b0;
    an_on_s  = '0;
    if (en_sel_s) begin
      seg_on_s = lz_s ? 7'h00 : hex_glyph(nib_s);
      dp_on_s  = dp_sel_s;
      an_on_s  = an_hot_s;
    end else begin
      seg_on_s = 7'h00;
      dp_on_s  = 1'b0;
      an_on_s  = '0;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      idx_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
      if (step_s) begin
        cnt_r <= '0;
        idx_r <= wrap_s ? '0 : idx_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Pending/shown buffers; a load coinciding with the wrap bypasses straight to the shown buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pdata_r <= '0;
      pdp_r   <= '0;
      pv_r    <= 1'b0;
      sdata_r <= '0;
      sdp_r   <= '0;
    end else begin
      if (bus.load) begin
        pdata_r <= bus.data;
        pdp_r   <= bus.dp;
      end
      if (wrap_s && bus.load) begin
        sdata_r <= bus.data;
        sdp_r   <= bus.dp;
        pv_r    <= 1'b0;
      end else if (wrap_s && pv_r) begin
        sdata_r <= pdata_r;
        sdp_r   <= pdp_r;
        pv_r    <= 1'b0;
      end else if (bus.load) begin
        pv_r <= 1'b1;
      end
    end
  end

  // Output register with polarity applied; frame_tick lines up with digit 0 appearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r        <= {7{ACTIVE_LOW}};
      dp_out_r     <= ACTIVE_LOW;
      an_r         <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_tick_r <= 1'b0;
    end else begin
      seg_r        <= seg_on_s ^ {7{ACTIVE_LOW}};
      dp_out_r     <= dp_on_s ^ ACTIVE_LOW;
      an_r         <= an_on_s ^ {NUM_DIGITS{ACTIVE_LOW}};
      frame_tick_r <= wrap_r;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp_out     = dp_out_r;
  assign bus.an         = an_r;
  assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: stimulus pushes expected outputs from a
// cycle-count reference model, a negedge monitor pops and compares.
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int SD    = 3;
  localparam bit AL    = 1'b1;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .ACTIVE_LOW(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         tick;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: edges since reset release plus the shown/pending values.
  int             k;
  logic [4*N-1:0] shown, pend;
  logic [N-1:0]   shown_dp, pend_dp;
  bit             pv;

  string glyph_letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                                "acdefg", "abc", "abcdefg", "abcfg", "abcefg",
                                "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(int v);
    logic [6:0] m;
    string      s;
    m = 7'h00;
    s = glyph_letters[v];
    for (int j = 0; j < s.len(); j++) m[int'(s[j]) - 97] = 1'b1;
    return m;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   idx;
    int   above;
    idx   = (k / SD) % N;
    above = int'(shown >> (4 * idx));
    e.seg = 7'h00;
    e.dp  = 1'b0;
    e.an  = '0;
    if (bus.digit_en[idx]) begin
      e.an = N'(1) << idx;
      e.dp = shown_dp[idx];
      if (!(bus.blank_lz && idx > 0 && above == 0)) e.seg = glyph(above % 16);
    end
    e.tick = (k > 0) && (k % FRAME == 0);
    if (AL) begin
      e.seg = ~e.seg;
      e.dp  = ~e.dp;
      e.an  = ~e.an;
    end
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    if (rst) begin
      e.seg    = {7{AL}};
      e.dp     = AL;
      e.an     = {N{AL}};
      e.tick   = 1'b0;
      k        = 0;
      shown    = '0;
      shown_dp = '0;
      pend     = '0;
      pend_dp  = '0;
      pv       = 1'b0;
    end else begin
      e = model_out();
      if (bus.load) begin
        pend    = bus.data;
        pend_dp = bus.dp;
        pv      = 1'b1;
      end
      if ((k + 1) % FRAME == 0 && pv) begin
        shown    = pend;
        shown_dp = pend_dp;
        pv       = 1'b0;
      end
      k++;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic run_to_wrap();
    while ((k + 1) % FRAME != 0) cyc();
  endtask

  task automatic load_val(input logic [4*N-1:0] d, input logic [N-1:0] p);
    bus.data = d;
    bus.dp   = p;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("seg", 32'(bus.seg), 32'(mon_e.seg));
        check("dp_out", 32'(bus.dp_out), 32'(mon_e.dp));
        check("an", 32'(bus.an), 32'(mon_e.an));
        check("frame_tick", 32'(bus.frame_tick), 32'(mon_e.tick));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          guard;
    rst          = 1'b1;
    bus.data     = '0;
    bus.dp       = '0;
    bus.digit_en = '1;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (30) cyc();

    // Mid-frame load, then back-to-back loads where the last must win.
    run_to_wrap();
    repeat (5) cyc();
    load_val(16'h12AF, 4'b0100);
    repeat (20) cyc();
    run_to_wrap();
    repeat (2) cyc();
    load_val(16'h1111, 4'b0000);
    repeat (3) cyc();
    load_val(16'h2222, 4'b0001);
    repeat (16) cyc();

    // Load exactly on the wrap cycle.
    run_to_wrap();
    load_val(16'h3C5E, 4'b1000);
    repeat (14) cyc();

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load_val(16'h0050, 4'b0000);
    repeat (26) cyc();
    load_val(16'h0000, 4'b0100);
    repeat (26) cyc();
    bus.blank_lz = 1'b0;

    // Disabled digit slot, then mid-frame reset.
    bus.digit_en = 4'b1011;
    repeat (26) cyc();
    bus.digit_en = 4'hF;
    load_val(16'h9876, 4'b0011);
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (20) cyc();

    // Randomised traffic with a bias toward leading zeros.
    for (int i = 0; i < 400; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      if (bus.load) begin
        d        = $urandom & (32'h0000FFFF >> (4 * $urandom_range(0, 4)));
        bus.data = d[4*N-1:0];
        bus.dp   = N'($urandom);
      end
      if ($urandom_range(0, 31) == 0) bus.digit_en = N'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_lz = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    bus.load = 1'b0;
    rst      = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits. It accepts a packed hex value per digit plus decimal points and drives one shared segment bus while scanning the digit selects at a fixed prescaled rate. New values are double-buffered and committed only at frame boundaries, so a refresh frame never shows mixed old and new data. Optional leading-zero blanking applies at runtime. Sits between the CPU's memory-mapped display register and the board pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 1..8.
- SCAN_DIV, 50000, clock cycles each digit is held; legal ≥1.
- ACTIVE_LOW, 1, 1: seg, dp_out and an are driven low-active; 0: high-active.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  4*NUM_DIGITS  hex nibble per digit; digit i = data[4i+3:4i], digit 0 rightmost.
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  per-digit enable, used live (not buffered).
- blank_lz  in  1  leading-zero blanking enable, used live.
- load  in  1  one-cycle strobe capturing data and dp into the pending buffer.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp_out  out  1  decimal point of the currently selected digit.
- an  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW).
- frame_tick  out  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0.

## Operation
- State: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), pending buffer {pdata,pdp}, pending flag pv, shown buffer {sdata,sdp}.
- cnt increments every cycle; at SCAN_DIV-1 it returns to 0 and idx advances; idx at NUM_DIGITS-1 wraps to 0 (wrap event). SCAN_DIV=1: idx advances every cycle.
- load=1: pdata<=data, pdp<=dp, pv<=1. Later loads before commit overwrite; the last one wins.
- Wrap event: if load=1 that same cycle, sdata/sdp take data/dp directly and pv<=0; else if pv=1, sdata/sdp<=pdata/pdp and pv<=0; else unchanged.
- Decode of nibble: 0..F → standard hex glyphs (0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc; 8 all; 9 abcfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg), seg[0]=a.
- Leading-zero blank: with blank_lz=1, digit i>0 is blanked when sdata nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never LZ-blanked. A blanked digit drives segments off but still shows its sdp bit.
- digit_en[i]=0: when idx=i, an is all-inactive, segments and dp are off. Scan timing is unaffected.
- Outputs are registered: seg/dp_out/an reflect idx, sdata, sdp and the live inputs of the previous cycle.
- ACTIVE_LOW inverts seg, dp_out and an at the output register; frame_tick is always active-high.

## Timing
- Reset (rst=1 at an edge): cnt=0, idx=0, pv=0, sdata=0, sdp=0, pdata=0, pdp=0, frame_tick=0, an all-inactive, seg and dp_out off (all 1 when ACTIVE_LOW=1). Reset overrides load and wrap.
- First edge after rst falls: the outputs show digit 0 (value 0, "0" glyph) with an[0] active.
- Each digit is selected for exactly SCAN_DIV cycles. A frame lasts NUM_DIGITS*SCAN_DIV cycles.
- frame_tick goes high the cycle after the wrap edge, aligned with an[0] becoming active, and lasts 1 cycle. First frame_tick comes NUM_DIGITS*SCAN_DIV cycles after reset release.
- Latency from load to display: the new value appears on the outputs one cycle after the next wrap edge. Worst case is one frame plus 1 cycle; load on the wrap cycle gives 1 cycle.
- NUM_DIGITS=1: a wrap occurs every SCAN_DIV cycles, and an[0] stays active continuously when enabled.
- Changes to digit_en and blank_lz take effect on the next edge, with no frame alignment.

## Test plan
- Reset with NUM_DIGITS=4, SCAN_DIV=3, ACTIVE_LOW=1, digit_en=4'hF, idle. Require an=1110, 1101, 1011, 0111 each for 3 cycles, seg=7'b1000000 ("0") throughout, and frame_tick every 12 cycles.
- Load data=16'h12AF, dp=4'b0100 mid-frame. Require the old glyphs until the wrap, then F, A, 2, 1 on digits 0..3 from the cycle an[0] activates, with dp_out low only while an[2] is active.
- Load 16'h1111 and then 16'h2222 in the same frame. Require only 2222 to be displayed after the wrap. Load exactly on the wrap cycle. Require the value to be visible 1 cycle later.
- Set blank_lz=1 with data=16'h0050. Require digits 3 and 2 blank, digit 1 "5", digit 0 "0". With data=16'h0000, require only digit 0 lit, showing "0".
- Set digit_en=4'b1011. Require an all-inactive with segments off during digit 2's slot while the other slots are unchanged. Pulse rst mid-frame. Require the reset values on the next edge and scanning to restart at digit 0.
